alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Sequential front end that drives the combinational 8-bit ALU datapath from a byte-wide valid/ready stream.
- Accepts a frame of three bytes: command, operand A, operand B.
- Presents the operands and function to the ALU, registers its result, carry/borrow and status flag, and returns them on a valid/ready result port.
- Keeps a carry/borrow register so that multi-byte add/subtract can be chained LSB-first.

Parameters:
DATA_WIDTH, `DATA_WIDTH (8), byte width of operands, results and the input stream.
CONTROL_WIDTH, `CONTROL_WIDTH (2), width of the ALU function select.

Ports:
clk_i  input  1  clock, rising-edge.
rst_i  input  1  reset, asynchronous, active-high.
clear_i  input  1  synchronous abort: state to CMD, carry register and chain-zero cleared.
in_data_i  input  DATA_WIDTH  frame byte.
in_valid_i  input  1  in_data_i valid.
in_ready_o  output  1  sequencer accepts a byte this cycle.
a8_o  output  DATA_WIDTH  to ALU a8_i.
b8_o  output  DATA_WIDTH  to ALU b8_i.
f8_o  output  CONTROL_WIDTH  to ALU f8_i.
carry_borrow_o  output  1  to ALU carry_borrow_i.
y8_i  input  DATA_WIDTH  from ALU y8_o.
carry_borrow_i  input  1  from ALU carry_borrow_o.
status_flag_i  input  2  from ALU status_flag_o.
res_data_o  output  DATA_WIDTH  registered ALU result.
res_carry_o  output  1  registered carry/borrow out.
res_status_o  output  2  registered ALU status flag.
res_chain_zero_o  output  1  all bytes of the current chain are zero.
res_valid_o  output  1  result valid.
res_ready_i  input  1  consumer accepts the result.

Behaviour:
- Handshakes: an input byte transfers on a rising edge where in_valid_i && in_ready_o. A result transfers where res_valid_o && res_ready_i.
- Command byte fields:
  - [1:0] f, the ALU function select.
  - [2] cin, the explicit carry-in.
  - [3] chain: 1 selects the stored carry register as carry-in instead of cin.
  - [7:4] reserved and ignored.
- FSM states: CMD, OPA, OPB, EXEC, RESULT.
  - CMD: accept byte, latch f8_o and carry_borrow_o (cin or carry register per chain), latch chain bit, go to OPA.
  - OPA: accept byte into a8_o, go to OPB.
  - OPB: accept byte into b8_o, go to EXEC.
  - EXEC: one cycle, ALU inputs stable. At the edge: capture y8_i, carry_borrow_i, status_flag_i into the res_* registers; load the carry register with carry_borrow_i; update chain-zero; go to RESULT.
  - RESULT: res_valid_o=1 and held stable until res_ready_i, then go to CMD.
- in_ready_o = 1 exactly in CMD/OPA/OPB, decoded combinationally from state. No input is accepted in EXEC/RESULT, and in_ready_o never depends on in_valid_i.
- Latency: res_valid_o rises one edge after the OPB-accept edge. With res_ready_i held high, throughput is one frame per 5 cycles.
- Chain-zero: res_chain_zero_o = (y8_i==0) when chain=0, else (y8_i==0) && previous res_chain_zero_o.
- Carry register is updated on every EXEC, including non-add/sub ops, where the ALU supplies 0.
- Reset (rst_i high, asynchronous):
  - State goes to CMD.
  - Cleared to 0: a8_o, b8_o, f8_o, carry_borrow_o, the carry register, res_data_o, res_carry_o, res_status_o, res_valid_o.
  - res_chain_zero_o goes to 1.
  - in_ready_o reads 1 while reset is asserted.
  - Reset mid-frame discards the partial frame. Reset while in RESULT drops the result.
- clear_i:
  - Has priority over any handshake in the same cycle; the byte or result offered that cycle is not consumed.
  - Puts state in CMD, clears the carry register and res_valid_o, and sets res_chain_zero_o=1.
  - Operand and res_data registers hold their values.
- in_valid_i low in any accept state leaves that state unchanged; there is no timeout.

Decomposition:
- Shared defines header (existing) supplies `DATA_WIDTH, `CONTROL_WIDTH, `OUTPUT_A_PLUS_B, `OUTPUT_A_MINUS_B, `ZERO_FLAG, `OVERFLOW_FLAG, `NEGATIVE_FLAG and `DEFAULT_FLAG.
- Add to that header:
  - The FSM state encodings (3 bits).
  - Command field positions: CMD_F_LSB=0, CMD_CIN_BIT=2, CMD_CHAIN_BIT=3.
- No sub-module in the sequencer itself.
- The integration top instantiates alu_sequencer plus eight_bit_alu; that top is the test harness.

Test Plan:
- Reset during OPA with a partial frame → all outputs at reset values, in_ready_o=1, next three bytes are parsed as a fresh frame.
- Add, no chain: cmd f=`OUTPUT_A_PLUS_B, cin=0; A=0x12, B=0x34 → res_data_o=0x46, res_carry_o=0, res_status_o=`DEFAULT_FLAG; res_valid_o rises one edge after B is accepted.
- 16-bit chain 0x01FF+0x0001:
  - Low frame (chain=0, cin=0) → 0x00, carry 1, status `OVERFLOW_FLAG.
  - High frame (chain=1) → 0x02, carry 0, res_chain_zero_o=0.
- Subtract: f=`OUTPUT_A_MINUS_B, A=0x05, B=0x07, cin=0 → res_data_o=0xFE, res_carry_o=1, res_status_o=`NEGATIVE_FLAG.
- Backpressure: res_ready_i low 4 cycles → res_* stable, in_ready_o=0, in_valid_i ignored. Result transfers the cycle res_ready_i rises, then CMD.
- clear_i asserted in OPB with in_valid_i high → B byte not consumed, state CMD, carry register 0. A following chain=1 add of 0xFF+0x00 gives 0xFF, carry 0.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared ALU definitions (widths, function selects, status flags) plus the
// sequencer's state encodings and command-byte field positions.
`ifndef ALU_SEQUENCER_DEFINES
`define ALU_SEQUENCER_DEFINES
`define DATA_WIDTH       8
`define CONTROL_WIDTH    2
`define OUTPUT_A_PLUS_B  2'b00
`define OUTPUT_A_MINUS_B 2'b01
`define DEFAULT_FLAG     2'b00
`define ZERO_FLAG        2'b01
`define OVERFLOW_FLAG    2'b10
`define NEGATIVE_FLAG    2'b11
`define SEQ_ST_CMD       3'd0
`define SEQ_ST_OPA       3'd1
`define SEQ_ST_OPB       3'd2
`define SEQ_ST_EXEC      3'd3
`define SEQ_ST_RESULT    3'd4
`define CMD_F_LSB        0
`define CMD_CIN_BIT      2
`define CMD_CHAIN_BIT    3
`endif

package alu_sequencer_pkg;

  localparam int DATA_W = `DATA_WIDTH;
  localparam int CTRL_W = `CONTROL_WIDTH;

  localparam int CMD_F_LSB     = `CMD_F_LSB;
  localparam int CMD_CIN_BIT   = `CMD_CIN_BIT;
  localparam int CMD_CHAIN_BIT = `CMD_CHAIN_BIT;

  localparam logic [1:0] FN_ADD = `OUTPUT_A_PLUS_B;
  localparam logic [1:0] FN_SUB = `OUTPUT_A_MINUS_B;

  localparam logic [1:0] FLAG_DEFAULT  = `DEFAULT_FLAG;
  localparam logic [1:0] FLAG_ZERO     = `ZERO_FLAG;
  localparam logic [1:0] FLAG_OVERFLOW = `OVERFLOW_FLAG;
  localparam logic [1:0] FLAG_NEGATIVE = `NEGATIVE_FLAG;

  typedef enum logic [2:0] {
    ST_CMD    = `SEQ_ST_CMD,
    ST_OPA    = `SEQ_ST_OPA,
    ST_OPB    = `SEQ_ST_OPB,
    ST_EXEC   = `SEQ_ST_EXEC,
    ST_RESULT = `SEQ_ST_RESULT
  } seq_state_e;

endpackage

// File: rtl/alu_sequencer.sv
// Byte-stream front end for the 8-bit ALU: parses cmd/A/B frames, runs one
// ALU cycle, and returns result, carry and status on a valid/ready port.
//
// state  | meaning
// CMD    | wait for command byte, latch function and carry-in
// OPA    | wait for operand A
// OPB    | wait for operand B
// EXEC   | ALU inputs stable for one cycle, result captured at the edge
// RESULT | result valid, held until the consumer takes it
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_W,
  parameter int CONTROL_WIDTH = CTRL_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic [DATA_WIDTH-1:0]    in_data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [DATA_WIDTH-1:0]    a8_o,
  output logic [DATA_WIDTH-1:0]    b8_o,
  output logic [CONTROL_WIDTH-1:0] f8_o,
  output logic                     carry_borrow_o,
  input  logic [DATA_WIDTH-1:0]    y8_i,
  input  logic                     carry_borrow_i,
  input  logic [1:0]               status_flag_i,
  output logic [DATA_WIDTH-1:0]    res_data_o,
  output logic                     res_carry_o,
  output logic [1:0]               res_status_o,
  output logic                     res_chain_zero_o,
  output logic                     res_valid_o,
  input  logic                     res_ready_i
);

  seq_state_e r_state;
  seq_state_e w_next_state;

  logic [DATA_WIDTH-1:0]    r_a;
  logic [DATA_WIDTH-1:0]    r_b;
  logic [CONTROL_WIDTH-1:0] r_f;
  logic                     r_cb;
  logic                     r_carry;
  logic                     r_chain;
  logic [DATA_WIDTH-1:0]    r_res_data;
  logic                     r_res_carry;
  logic [1:0]               r_res_status;
  logic                     r_chain_zero;

  logic w_in_fire;
  logic w_res_fire;
  logic w_y_zero;

  always_comb begin
    in_ready_o = 1'b0;
    res_valid_o = 1'b0;
    case (r_state)
      ST_CMD, ST_OPA, ST_OPB: in_ready_o = 1'b1;
      ST_RESULT:              res_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign w_in_fire  = in_valid_i && in_ready_o && !clear_i;
  assign w_res_fire = res_valid_o && res_ready_i && !clear_i;
  assign w_y_zero   = (y8_i == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_CMD;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (clear_i) begin
      w_next_state = ST_CMD;
    end else begin
      case (r_state)
        ST_CMD:    if (w_in_fire) w_next_state = ST_OPA;
        ST_OPA:    if (w_in_fire) w_next_state = ST_OPB;
        ST_OPB:    if (w_in_fire) w_next_state = ST_EXEC;
        ST_EXEC:   w_next_state = ST_RESULT;
        ST_RESULT: if (w_res_fire) w_next_state = ST_CMD;
        default:   w_next_state = ST_CMD;
      endcase
    end
  end

  // Operand and result registers intentionally survive clear_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a          <= '0;
      r_b          <= '0;
      r_f          <= '0;
      r_cb         <= 1'b0;
      r_carry      <= 1'b0;
      r_chain      <= 1'b0;
      r_res_data   <= '0;
      r_res_carry  <= 1'b0;
      r_res_status <= 2'b00;
      r_chain_zero <= 1'b1;
    end else if (clear_i) begin
      r_carry      <= 1'b0;
      r_chain_zero <= 1'b1;
    end else begin
      case (r_state)
        ST_CMD: if (w_in_fire) begin
          r_f     <= in_data_i[CMD_F_LSB +: CONTROL_WIDTH];
          r_cb    <= in_data_i[CMD_CHAIN_BIT] ? r_carry : in_data_i[CMD_CIN_BIT];
          r_chain <= in_data_i[CMD_CHAIN_BIT];
        end
        ST_OPA: if (w_in_fire) r_a <= in_data_i;
        ST_OPB: if (w_in_fire) r_b <= in_data_i;
        ST_EXEC: begin
          r_res_data   <= y8_i;
          r_res_carry  <= carry_borrow_i;
          r_res_status <= status_flag_i;
          r_carry      <= carry_borrow_i;
          r_chain_zero <= r_chain ? (w_y_zero && r_chain_zero) : w_y_zero;
        end
        default: ;
      endcase
    end
  end

  assign a8_o             = r_a;
  assign b8_o             = r_b;
  assign f8_o             = r_f;
  assign carry_borrow_o   = r_cb;
  assign res_data_o       = r_res_data;
  assign res_carry_o      = r_res_carry;
  assign res_status_o     = r_res_status;
  assign res_chain_zero_o = r_chain_zero;

endmodule

// File: tb/tb_alu_sequencer.sv
// Harness for alu_sequencer with a behavioural 8-bit ALU in the loop; checks
// directed and random frames against a frame-level reference model.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       clear_i = 1'b0;
  logic [7:0] in_data_i = 8'h00;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o;
  logic [7:0] a8_o, b8_o;
  logic [1:0] f8_o;
  logic       carry_borrow_o;
  logic [7:0] y8_i;
  logic       carry_borrow_i;
  logic [1:0] status_flag_i;
  logic [7:0] res_data_o;
  logic       res_carry_o;
  logic [1:0] res_status_o;
  logic       res_chain_zero_o;
  logic       res_valid_o;
  logic       res_ready_i = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  // Frame-level model state: stored carry and chain-zero.
  logic m_carry = 1'b0;
  logic m_cz    = 1'b1;

  always #5 clk_i = ~clk_i;

  alu_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .a8_o(a8_o), .b8_o(b8_o), .f8_o(f8_o), .carry_borrow_o(carry_borrow_o),
    .y8_i(y8_i), .carry_borrow_i(carry_borrow_i), .status_flag_i(status_flag_i),
    .res_data_o(res_data_o), .res_carry_o(res_carry_o), .res_status_o(res_status_o),
    .res_chain_zero_o(res_chain_zero_o), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i)
  );

  // Returns {carry_out, status[1:0], y[7:0]}.
  function automatic logic [10:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] f, input logic ci);
    logic [8:0] s;
    logic [1:0] st;
    s = 9'd0;
    case (f)
      FN_ADD:  s = {1'b0, a} + {1'b0, b} + {8'd0, ci};
      FN_SUB:  s = {1'b0, a} - {1'b0, b} - {8'd0, ci};
      2'b10:   s = {1'b0, a & b};
      default: s = {1'b0, a | b};
    endcase
    if (s[8] && f == FN_ADD)      st = FLAG_OVERFLOW;
    else if (s[8] && f == FN_SUB) st = FLAG_NEGATIVE;
    else if (s[7:0] == 8'd0)      st = FLAG_ZERO;
    else                          st = FLAG_DEFAULT;
    return {s[8], st, s[7:0]};
  endfunction

  logic [10:0] w_alu;
  assign w_alu          = alu_fn(a8_o, b8_o, f8_o, carry_borrow_o);
  assign y8_i           = w_alu[7:0];
  assign status_flag_i  = w_alu[9:8];
  assign carry_borrow_i = w_alu[10];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    bit done = 0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    for (int n = 0; n < 50 && !done; n++) begin
      if (in_ready_o) done = 1;
      step();
    end
    if (!done) check_val("send_timeout", {31'd0, in_ready_o}, 32'd1);
    in_valid_i = 1'b0;
  endtask

  // Runs one frame, stalls the consumer for `stall` cycles, then takes the result.
  task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [7:0] a,
                           input logic [7:0] b, input int stall);
    logic [10:0] e;
    logic        ci;
    logic        chain;
    chain = cmd[CMD_CHAIN_BIT];
    ci    = chain ? m_carry : cmd[CMD_CIN_BIT];
    e     = alu_fn(a, b, cmd[1:0], ci);
    m_carry = e[10];
    m_cz    = (e[7:0] == 8'd0) && (chain ? m_cz : 1'b1);

    send_byte(cmd);
    send_byte(a);
    send_byte(b);
    check_val({tag, "_valid_exec"}, {31'd0, res_valid_o}, 32'd0);
    step();
    check_val({tag, "_valid"}, {31'd0, res_valid_o}, 32'd1);
    check_val({tag, "_data"},  {24'd0, res_data_o}, {24'd0, e[7:0]});
    check_val({tag, "_carry"}, {31'd0, res_carry_o}, {31'd0, e[10]});
    check_val({tag, "_status"}, {30'd0, res_status_o}, {30'd0, e[9:8]});
    check_val({tag, "_cz"}, {31'd0, res_chain_zero_o}, {31'd0, m_cz});
    check_val({tag, "_ops"}, {14'd0, f8_o, b8_o, a8_o}, {14'd0, cmd[1:0], b, a});
    for (int s = 0; s < stall; s++) begin
      in_valid_i = 1'b1;
      in_data_i  = 8'($urandom);
      check_val({tag, "_stall_rdy"}, {31'd0, in_ready_o}, 32'd0);
      step();
      check_val({tag, "_stall_hold"},
                {21'd0, res_valid_o, res_carry_o, res_status_o, res_data_o},
                {21'd0, 1'b1, e[10], e[9:8], e[7:0]});
    end
    in_valid_i  = 1'b0;
    res_ready_i = 1'b1;
    step();
    res_ready_i = 1'b0;
    check_val({tag, "_done"}, {30'd0, res_valid_o, in_ready_o}, 32'd1);
  endtask

  initial begin
    #12;
    check_val("rst_outs", {11'd0, a8_o, b8_o, f8_o, carry_borrow_o},  32'd0);
    check_val("rst_res", {20'd0, res_valid_o, res_chain_zero_o, res_status_o, res_carry_o, res_data_o[6:0]},
              32'h400);
    check_val("rst_rdy", {31'd0, in_ready_o}, 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    step();

    // Partial frame cut by async reset
    send_byte(8'h00);
    send_byte(8'hAA);
    #2 rst_i = 1'b1;
    #1;
    check_val("midrst_ops", {14'd0, f8_o, b8_o, a8_o}, 32'd0);
    check_val("midrst_rdy", {29'd0, in_ready_o, res_valid_o, res_chain_zero_o}, 32'd5);
    step();
    rst_i = 1'b0;
    m_carry = 1'b0;
    m_cz    = 1'b1;

    run_frame("add",  8'h00, 8'h12, 8'h34, 0);
    run_frame("lo16", 8'h00, 8'hFF, 8'h01, 0);
    run_frame("hi16", 8'h08, 8'h01, 8'h00, 0);
    run_frame("sub",  8'h01, 8'h05, 8'h07, 4);

    // Clear in OPB: set carry to 1 first so that clearing it is observable
    run_frame("preclr", 8'h00, 8'hFF, 8'h01, 0);
    send_byte(8'h00);
    send_byte(8'h11);
    in_valid_i = 1'b1;
    in_data_i  = 8'h22;
    clear_i    = 1'b1;
    step();
    clear_i    = 1'b0;
    in_valid_i = 1'b0;
    check_val("clr_state", {30'd0, in_ready_o, res_valid_o}, 32'd2);
    check_val("clr_cz", {31'd0, res_chain_zero_o}, 32'd1);
    check_val("clr_a_hold", {24'd0, a8_o}, 32'h11);
    m_carry = 1'b0;
    m_cz    = 1'b1;
    run_frame("postclr", 8'h08, 8'hFF, 8'h00, 0);

    for (int i = 0; i < 40; i++)
      run_frame("rnd", 8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

endmodule
